dual_sng_lfsr: RTL and testbench
================================

// Module: dual_sng_lfsr
// PURPOSE
//  Two-channel stochastic number generator (SNG) that sits directly upstream of the sequential
//  recorrelator and drives its x/y inputs. It latches two N-bit unsigned probabilities (px, py) and
//  emits one fixed-length pair of unipolar bitstreams, one bit per clock, by comparing each value
//  against an LFSR. A start/done handshake frames the stream; hold freezes it for backpressure.
// PARAMETERS
//  N       8          comparator/LFSR width; legal 4..8
//  LEN     (1<<N)-1   stream length in bits; legal 1..65535
//  SEED_X  1          initial LFSR_X state; a value of 0 is replaced by 1
//  SEED_Y  'h5A       initial LFSR_Y state (masked to N bits); a value of 0 is replaced by 1
// PORTS
//  clk    in   1  clock, rising edge
//  rst    in   1  asynchronous active-high reset
//  start  in   1  request a new stream; sampled only in IDLE
//  px     in   N  probability for x, value/(2^N-1); sampled on the accepted start
//  py     in   N  probability for y; sampled on the accepted start
//  hold   in   1  stall; freezes the stream while high
//  x      out  1  stochastic bit for channel x; feeds recorrelator x
//  y      out  1  stochastic bit for channel y; feeds recorrelator y
//  valid  out  1  x/y carry a stream bit this cycle
//  busy   out  1  state != IDLE
//  done   out  1  one-cycle pulse after the last bit
// BEHAVIOUR
//  - Reset (asynchronous, any time, including mid-stream):
//    - state=IDLE, counter=0, LFSRs=seeds, latched px/py=0.
//    - x=y=valid=busy=done=0.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1 at edge T:
//    - latch px/py; load LFSR_X=SEED_X and LFSR_Y=SEED_Y; cnt=0; go to RUN.
//    - The first valid bit appears in cycle T+1 (one-cycle latency from start).
//  - RUN:
//    - valid = ~hold.
//    - x = (lfsr_x <= px_q) & valid; y = (lfsr_y <= py_q) & valid. Unsigned N-bit compare.
//    - x/y are combinational from registers only (no path from px/py/start).
//    - At each edge with hold=0: both LFSRs step and cnt increments.
//    - cnt==LEN-1 with hold=0 -> DONE.
//    - hold=1: LFSRs, cnt and state are unchanged; x=y=0.
//  - DONE: done=1, valid=0, busy=1 for exactly one cycle, then IDLE.
//  - start outside IDLE is ignored; there is no queuing. A new start may be accepted on the
//    first IDLE cycle after DONE.
//  - LFSR: Fibonacci shift-left, feedback into bit 0 = XOR of taps.
//    - Taps by N: 4 {3,2}; 5 {4,2}; 6 {5,4}; 7 {6,5}; 8 {7,5,4,3}.
//    - Period 2^N-1, never reaches 0.
//  - Over a full period (LEN=2^N-1) the ones count is exactly px (resp. py).
//    - px=0 gives all zeros; px=2^N-1 gives all ones.
//  - cnt width is $clog2(LEN+1); cnt never wraps within a stream.
//  - Without the macro, the two LFSRs are independent registers with distinct seeds, giving
//    near-uncorrelated streams (the recorrelator's target use case).
// CONFIGURATION
//  SNG_SHARED_RNS_EN
//   - Defined: LFSR_Y is removed and y compares py_q against lfsr_x. SEED_Y is unused. Streams
//     are maximally positively correlated (SCC=+1).
//   - Undefined: separate LFSR_Y as above.
// TESTING
//  1. N=8, LEN=255, px=100, py=37, one start pulse: exactly 255 valid cycles; x ones=100,
//     y ones=37; done pulses once at cycle 256 after start; busy low after that.
//  2. px=0, py=255: x is 0 and y is 1 on every valid cycle; counts are 0 and 255.
//  3. hold=1 for 10 cycles mid-stream: valid=0 and x=y=0 while held; totals unchanged (100/37);
//     done is delayed by exactly 10 cycles.
//  4. start held high through the whole stream: no restart before DONE; the second stream begins
//     the cycle after IDLE is re-entered.
//  5. rst asserted at bit 50: all outputs 0 immediately; a new start gives the full
//     255-bit stream again.
//  6. SNG_SHARED_RNS_EN defined, px=py=128: x==y on every cycle; without the macro, x!=y on at
//     least one cycle.

Source files
------------

// File: rtl/dual_sng_lfsr.sv
// Two-channel LFSR stochastic number generator with start/done framing and hold.
// Define SNG_SHARED_RNS_EN to drive both comparators from a single LFSR (SCC=+1).
module dual_sng_lfsr #(
   parameter int N      = 8,
   parameter int LEN    = (1 << N) - 1,
   parameter int SEED_X = 1,
   parameter int SEED_Y = 'h5A
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] px,
   input  logic [N-1:0] py,
   input  logic         hold,
   output logic         x,
   output logic         y,
   output logic         valid,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   // Zero is the LFSR lock-up state, so a zero seed is replaced by 1.
   localparam logic [N-1:0] SX = (N'(SEED_X) == '0) ? N'(1) : N'(SEED_X);
   localparam logic [N-1:0] SY = (N'(SEED_Y) == '0) ? N'(1) : N'(SEED_Y);

   localparam logic [N-1:0] TAPS =
      (N == 4) ? N'('h0C) :
      (N == 5) ? N'('h14) :
      (N == 6) ? N'('h30) :
      (N == 7) ? N'('h60) : N'('hB8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  lfsr_x;
   logic [N-1:0]  px_q;
   logic [N-1:0]  py_q;
   logic [N-1:0]  rn_y;

   function automatic logic [N-1:0] step(input logic [N-1:0] s);
      return {s[N-2:0], ^(s & TAPS)};
   endfunction

`ifdef SNG_SHARED_RNS_EN
   assign rn_y = lfsr_x;
`else
   logic [N-1:0] lfsr_y;

   assign rn_y = lfsr_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_y <= SY;
      end else if (state == S_IDLE && start) begin
         lfsr_y <= SY;
      end else if (state == S_RUN && !hold) begin
         lfsr_y <= step(lfsr_y);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         lfsr_x <= SX;
         px_q   <= '0;
         py_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  px_q   <= px;
                  py_q   <= py;
                  lfsr_x <= SX;
                  cnt    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (!hold) begin
                  lfsr_x <= step(lfsr_x);
                  cnt    <= cnt + CW'(1);
                  if (cnt == LAST) state <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign valid = (state == S_RUN) & ~hold;
   assign x     = (lfsr_x <= px_q) & valid;
   assign y     = (rn_y <= py_q) & valid;
   assign busy  = (state != S_IDLE);
   assign done  = (state == S_DONE);

endmodule

// File: tb/tb_dual_sng_lfsr.sv
// Directed self-checking bench for dual_sng_lfsr (N=8, LEN=255).
// Honours SNG_SHARED_RNS_EN when it is defined for the build.
module tb_dual_sng_lfsr;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] px;
   logic [7:0] py;
   logic       hold;
   logic       x;
   logic       y;
   logic       valid;
   logic       busy;
   logic       done;

   int n_cmp;
   int n_bad;

   dual_sng_lfsr dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .px    (px),
      .py    (py),
      .hold  (hold),
      .x     (x),
      .y     (y),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts one stream and records it cycle by cycle; cycle 1 is the
   // first cycle after the accepting edge.
   task automatic run_stream(
      input  logic [7:0] a,
      input  logic [7:0] b,
      input  int         hold_at,
      input  int         hold_len,
      input  int         max_c,
      output int         nv,
      output int         nx,
      output int         ny,
      output int         dcyc,
      output int         dcnt,
      output int         hbad,
      output int         busy_after,
      output int         neq,
      output logic       fx,
      output logic       fy
   );
      nv = 0; nx = 0; ny = 0; dcyc = 0; dcnt = 0;
      hbad = 0; busy_after = 1; neq = 0; fx = 1'bx; fy = 1'bx;
      @(negedge clk);
      px = a; py = b; start = 1'b1;
      for (int c = 1; c <= max_c; c++) begin
         @(negedge clk);
         start = 1'b0;
         hold = (c >= hold_at) && (c < hold_at + hold_len);
         #1;
         if (valid) nv++;
         if (x) nx++;
         if (y) ny++;
         if (x !== y) neq++;
         if (c == 1) begin fx = x; fy = y; end
         if (hold && (valid || x || y)) hbad++;
         if (done) begin
            dcnt++;
            if (dcyc == 0) dcyc = c;
         end
         if (dcyc != 0 && c == dcyc + 1) begin
            busy_after = int'(busy);
            break;
         end
      end
      hold = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; hold = 1'b0; px = '0; py = '0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({x, y, valid, busy, done} !== 5'b0) begin
         $display("FAIL reset_held got %b want 00000", {x, y, valid, busy, done});
         n_bad++;
      end
      rst = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({x, y, valid, busy, done} !== 5'b0) begin
         $display("FAIL reset_idle got %b want 00000", {x, y, valid, busy, done});
         n_bad++;
      end
   endtask

   task automatic test_basic();
      int nv, nx, ny, dcyc, dcnt, hbad, ba, neq;
      logic fx, fy, fy_exp;
      run_stream(8'd100, 8'd37, 0, 0, 400,
                 nv, nx, ny, dcyc, dcnt, hbad, ba, neq, fx, fy);
`ifdef SNG_SHARED_RNS_EN
      fy_exp = 1'b1;
`else
      fy_exp = 1'b0;
`endif
      n_cmp++;
      if (nv !== 255) begin
         $display("FAIL basic_valid got %0d want 255", nv); n_bad++;
      end
      n_cmp++;
      if (nx !== 100) begin
         $display("FAIL basic_xones got %0d want 100", nx); n_bad++;
      end
      n_cmp++;
      if (ny !== 37) begin
         $display("FAIL basic_yones got %0d want 37", ny); n_bad++;
      end
      n_cmp++;
      if (dcyc !== 256) begin
         $display("FAIL basic_done_cycle got %0d want 256", dcyc); n_bad++;
      end
      n_cmp++;
      if (dcnt !== 1) begin
         $display("FAIL basic_done_pulses got %0d want 1", dcnt); n_bad++;
      end
      n_cmp++;
      if (ba !== 0) begin
         $display("FAIL basic_busy_after got %0d want 0", ba); n_bad++;
      end
      n_cmp++;
      if (fx !== 1'b1) begin
         $display("FAIL basic_first_x got %b want 1", fx); n_bad++;
      end
      n_cmp++;
      if (fy !== fy_exp) begin
         $display("FAIL basic_first_y got %b want %b", fy, fy_exp); n_bad++;
      end
   endtask

   task automatic test_extremes();
      int nv, nx, ny, dcyc, dcnt, hbad, ba, neq;
      logic fx, fy;
      run_stream(8'd0, 8'd255, 0, 0, 400,
                 nv, nx, ny, dcyc, dcnt, hbad, ba, neq, fx, fy);
      n_cmp++;
      if (nv !== 255) begin
         $display("FAIL ext_valid got %0d want 255", nv); n_bad++;
      end
      n_cmp++;
      if (nx !== 0) begin
         $display("FAIL ext_xones got %0d want 0", nx); n_bad++;
      end
      n_cmp++;
      if (ny !== 255) begin
         $display("FAIL ext_yones got %0d want 255", ny); n_bad++;
      end
   endtask

   task automatic test_hold();
      int nv, nx, ny, dcyc, dcnt, hbad, ba, neq;
      logic fx, fy;
      run_stream(8'd100, 8'd37, 50, 10, 400,
                 nv, nx, ny, dcyc, dcnt, hbad, ba, neq, fx, fy);
      n_cmp++;
      if (hbad !== 0) begin
         $display("FAIL hold_quiet got %0d active cycles want 0", hbad); n_bad++;
      end
      n_cmp++;
      if (nv !== 255) begin
         $display("FAIL hold_valid got %0d want 255", nv); n_bad++;
      end
      n_cmp++;
      if (nx !== 100 || ny !== 37) begin
         $display("FAIL hold_ones got %0d/%0d want 100/37", nx, ny); n_bad++;
      end
      n_cmp++;
      if (dcyc !== 266) begin
         $display("FAIL hold_done_cycle got %0d want 266", dcyc); n_bad++;
      end
   endtask

   task automatic test_back_to_back();
      int   nv;
      int   dcnt;
      int   dcnt2;
      logic v257, b257, v258, b258;
      nv = 0; dcnt = 0; dcnt2 = 0;
      v257 = 1'bx; b257 = 1'bx; v258 = 1'bx; b258 = 1'bx;
      @(negedge clk);
      px = 8'd100; py = 8'd37; start = 1'b1;
      for (int c = 1; c <= 258; c++) begin
         @(negedge clk); #1;
         if (c <= 256 && valid) nv++;
         if (c <= 256 && done) dcnt++;
         if (c == 257) begin v257 = valid; b257 = busy; end
         if (c == 258) begin v258 = valid; b258 = busy; end
      end
      start = 1'b0;
      n_cmp++;
      if (nv !== 255 || dcnt !== 1) begin
         $display("FAIL b2b_first got %0d valid %0d done want 255 1", nv, dcnt);
         n_bad++;
      end
      n_cmp++;
      if ({v257, b257} !== 2'b00) begin
         $display("FAIL b2b_idle_gap got %b want 00", {v257, b257}); n_bad++;
      end
      n_cmp++;
      if ({v258, b258} !== 2'b11) begin
         $display("FAIL b2b_restart got %b want 11", {v258, b258}); n_bad++;
      end
      for (int c = 259; c <= 600; c++) begin
         @(negedge clk); #1;
         if (done) begin dcnt2++; break; end
      end
      n_cmp++;
      if (dcnt2 !== 1) begin
         $display("FAIL b2b_second_done got %0d want 1", dcnt2); n_bad++;
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int nv, nx, ny, dcyc, dcnt, hbad, ba, neq;
      logic fx, fy;
      @(negedge clk);
      px = 8'd100; py = 8'd37; start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({x, y, valid, busy, done} !== 5'b0) begin
         $display("FAIL midrst_outputs got %b want 00000", {x, y, valid, busy, done});
         n_bad++;
      end
      @(negedge clk);
      rst = 1'b0;
      run_stream(8'd100, 8'd37, 0, 0, 400,
                 nv, nx, ny, dcyc, dcnt, hbad, ba, neq, fx, fy);
      n_cmp++;
      if (nv !== 255 || nx !== 100 || ny !== 37) begin
         $display("FAIL midrst_stream got %0d/%0d/%0d want 255/100/37", nv, nx, ny);
         n_bad++;
      end
      n_cmp++;
      if (dcyc !== 256) begin
         $display("FAIL midrst_done_cycle got %0d want 256", dcyc); n_bad++;
      end
   endtask

   task automatic test_correlation();
      int nv, nx, ny, dcyc, dcnt, hbad, ba, neq;
      logic fx, fy;
      run_stream(8'd128, 8'd128, 0, 0, 400,
                 nv, nx, ny, dcyc, dcnt, hbad, ba, neq, fx, fy);
      n_cmp++;
`ifdef SNG_SHARED_RNS_EN
      if (neq !== 0) begin
         $display("FAIL corr_shared got %0d differing cycles want 0", neq);
         n_bad++;
      end
`else
      if (neq == 0) begin
         $display("FAIL corr_indep got %0d differing cycles want >0", neq);
         n_bad++;
      end
`endif
      n_cmp++;
      if (nx !== 128 || ny !== 128) begin
         $display("FAIL corr_ones got %0d/%0d want 128/128", nx, ny); n_bad++;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_basic();
      test_extremes();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      test_correlation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
